// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared opcodes, FSM states and operand-use decode
package pipeline_hazard_controller_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  function automatic logic rs1_used(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction
  function automatic logic rs2_used(input logic [6:0] op);
    return op inside {OP_STORE, OP_RTYPE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: MEM-stage data-memory request/ready handshake
interface pipeline_hazard_controller_if;
  logic MEM_DmemReq;
  logic MEM_DmemReady;
  modport master (output MEM_DmemReq, input MEM_DmemReady);
  modport slave (input MEM_DmemReq, output MEM_DmemReady);
  modport mon (input MEM_DmemReq, input MEM_DmemReady);
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: counter that sticks at all-ones, cleared asynchronously
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  // count enabled cycles until all-ones, then hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_o <= '0;
    else cnt_o <= cnt_o + W'(en_i && !(&cnt_o));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch flush and dmem freeze sequencing
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           ID_opcode,
  input  logic [4:0]           ID_ReadRegNum1,
  input  logic [4:0]           ID_ReadRegNum2,
  input  logic                 EX_cntl_MemRead,
  input  logic [4:0]           EX_WriteRegNum,
  input  logic                 EX_BranchTaken,
  pipeline_hazard_controller_if.mon dmem,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Write,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Write,
  output logic                 MEM_WB_Bubble,
  output logic                 MemTimeoutErr,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushCount
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          load_use, mem_stall, freeze, go, hold_id, stall_en, flush_en;
  assign load_use = EX_cntl_MemRead && EX_WriteRegNum != 5'd0 &&
                    ((rs1_used(ID_opcode) && EX_WriteRegNum == ID_ReadRegNum1) ||
                     (rs2_used(ID_opcode) && EX_WriteRegNum == ID_ReadRegNum2));
  assign mem_stall = dmem.MEM_DmemReq && !dmem.MEM_DmemReady;
  assign freeze    = state_q == ERR || mem_stall;
  assign go        = reset_n && !freeze;
  assign hold_id   = load_use && !EX_BranchTaken;
  assign PC_Write      = go && !hold_id;
  assign IF_ID_Write   = go && !hold_id;
  assign IF_ID_Flush   = go && EX_BranchTaken;
  assign ID_EX_Write   = go;
  assign ID_EX_Flush   = go && (EX_BranchTaken || load_use);
  assign EX_MEM_Write  = go;
  assign MEM_WB_Bubble = reset_n && freeze;
  assign MemTimeoutErr = err_q;
  assign stall_en = (mem_stall && state_q != ERR) || (go && hold_id);
  assign flush_en = go && EX_BranchTaken;
  // next state: enter wait on a stall, time out to ERR, release on ready
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    if (state_q != ERR) begin
      state_d = !mem_stall ? RUN : (state_q == MEM_WAIT && wait_q == WW'(MEM_TIMEOUT - 1)) ? ERR : MEM_WAIT;
      wait_d  = !mem_stall ? '0 : state_q == RUN ? WW'(1) : wait_q + WW'(1);
      err_d   = state_d == ERR;
    end
  end
  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  sat_counter #(.W(CNT_WIDTH)) u_stall (.clk(clk), .rst_n(reset_n), .en_i(stall_en), .cnt_o(StallCycles));
  sat_counter #(.W(CNT_WIDTH)) u_flush (.clk(clk), .rst_n(reset_n), .en_i(flush_en), .cnt_o(FlushCount));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random checks against a rule-level model
module tb_pipeline_hazard_controller;
  localparam int TMO = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [6:0] ID_opcode = '0;
  logic [4:0] ID_ReadRegNum1 = '0, ID_ReadRegNum2 = '0, EX_WriteRegNum = '0;
  logic EX_cntl_MemRead = 1'b0, EX_BranchTaken = 1'b0;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble, MemTimeoutErr;
  logic [3:0] StallCycles, FlushCount;
  int checks = 0, errors = 0;
  int m_stall = 0, m_flush = 0, m_wait = 0;
  bit m_err = 0;
  logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                          7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  pipeline_hazard_controller_if dif ();
  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .ID_opcode(ID_opcode), .ID_ReadRegNum1(ID_ReadRegNum1),
    .ID_ReadRegNum2(ID_ReadRegNum2), .EX_cntl_MemRead(EX_cntl_MemRead), .EX_WriteRegNum(EX_WriteRegNum),
    .EX_BranchTaken(EX_BranchTaken), .dmem(dif.mon), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Bubble(MEM_WB_Bubble), .MemTimeoutErr(MemTimeoutErr),
    .StallCycles(StallCycles), .FlushCount(FlushCount));
  always #5 clk = ~clk;
  function automatic logic [6:0] ctl();
    return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_regs();
    check("stall_cycles", 32'(StallCycles), m_stall);
    check("flush_count", 32'(FlushCount), m_flush);
    check("timeout_err", 32'(MemTimeoutErr), 32'(m_err));
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0;
    check("reset_ctl", 32'(ctl()), 0);
    check_regs();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask
  task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                      input logic mr, input logic br, input logic rq, input logic rd);
    bit ms, lu;
    logic [6:0] e;
    ID_opcode = op; ID_ReadRegNum1 = r1; ID_ReadRegNum2 = r2; EX_WriteRegNum = wr;
    EX_cntl_MemRead = mr; EX_BranchTaken = br; dif.MEM_DmemReq = rq; dif.MEM_DmemReady = rd;
    #2;
    ms = rq && !rd;
    lu = mr && wr != 0 && ((!(op inside {7'b0110111, 7'b0010111, 7'b1101111}) && wr == r1) ||
                           ((op inside {7'b0100011, 7'b0110011, 7'b1100011}) && wr == r2));
    // bit order: PC, IF/ID wr, IF/ID flush, ID/EX wr, ID/EX flush, EX/MEM wr, MEM/WB bubble
    e = (m_err || ms) ? 7'b0000001 : br ? 7'b1111110 : lu ? 7'b0001110 : 7'b1101010;
    check("ctl", 32'(ctl()), 32'(e));
    @(posedge clk); #1;
    if (m_err) ;
    else if (ms) begin
      if (m_stall < CMAX) m_stall++;
      m_wait++;
      if (m_wait >= TMO) m_err = 1;
    end else begin
      m_wait = 0;
      if (br) begin if (m_flush < CMAX) m_flush++; end
      else if (lu && m_stall < CMAX) m_stall++;
    end
    check_regs();
  endtask
  initial begin
    dif.MEM_DmemReq = 1'b0; dif.MEM_DmemReady = 1'b0;
    do_reset();
    step(7'b0110011, 5, 7, 5, 1, 0, 0, 0);
    step(7'b0110011, 5, 7, 5, 0, 0, 0, 0);
    step(7'b0110011, 0, 7, 0, 1, 0, 0, 0);
    step(7'b0110111, 5, 5, 5, 1, 0, 0, 0);
    step(7'b0100011, 1, 5, 5, 1, 0, 0, 0);
    step(7'b0010011, 1, 5, 5, 1, 0, 0, 0);
    step(7'b0110011, 5, 7, 5, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(7'b0010011, 1, 2, 3, 0, 1, 1, 0);
    step(7'b0010011, 1, 2, 3, 0, 1, 1, 1);
    step(7'b0010011, 1, 2, 3, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(7'b0010011, 1, 2, 3, 0, 0, 1, 0);
    step(7'b0010011, 1, 2, 3, 0, 1, 1, 1);
    do_reset();
    step(7'b0010011, 1, 2, 3, 0, 0, 1, 0);
    step(7'b0010011, 1, 2, 3, 0, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 17; i++) step(7'b1100011, 3, 4, 4, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(7'b1100011, 3, 4, 4, 0, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      step(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
